// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and state encoding for the 1-to-4 registered demux
//
// Purpose : default data/select widths and the buffer-state encoding used by
//           demux_1n4_reg and its one-entry buffer.
// Ports   : none (package).
package cpu_pkg;

   localparam int W_DEF  = 16;   // default data word width
   localparam int NS_DEF = 2;    // select width, four destinations
   localparam int NPORT  = 4;    // number of destination ports

   // BOSH: buffer empty, MBUSHUR: buffer holds a word waiting for its port
   typedef enum logic {
      BOSH    = 1'b0,
      MBUSHUR = 1'b1
   } state_t;

endpackage

// File: rtl/regjistri_buferi.sv
// rtl/regjistri_buferi.sv - one-entry register with load enable and synchronous active-low clear
//
// Purpose : holds {data, select} of the word waiting to leave the demux.
// Ports   : clk      - clock, rising edge
//           clear_n  - synchronous active-low clear, wins over load
//           load     - capture d on the next rising edge
//           d        - next contents
//           q        - stored contents
import cpu_pkg::*;

module regjistri_buferi #(
   parameter int WIDTH = W_DEF + NS_DEF
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/demux_1n4_reg.sv
// rtl/demux_1n4_reg.sv - registered 1-to-4 demux with valid/ready handshakes and transfer counter
//
// Purpose : accepts a word plus destination select, buffers it for one
//           cycle and presents it on the selected destination bus until
//           that destination takes it. Counts completed output transfers.
// Ports   : Clock        - clock, rising edge
//           Reset_n      - synchronous active-low reset
//           Hyrje        - source data word
//           S            - destination select, sampled with Hyrje
//           Hyrje_Valid  - source offers a word
//           Hyrje_Ready  - block accepts a word this cycle
//           Dalja0..3    - destination data buses (zero when not selected)
//           Dalja_Valid  - one-hot valid per destination
//           Dalja_Ready  - per-destination ready
//           Numeruesi    - count of completed output transfers, wraps
import cpu_pkg::*;

module demux_1n4_reg #(
   parameter int W  = W_DEF,
   parameter int NS = NS_DEF
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic [W-1:0]      Hyrje,
   input  logic [NS-1:0]     S,
   input  logic              Hyrje_Valid,
   output logic              Hyrje_Ready,
   output logic [W-1:0]      Dalja0,
   output logic [W-1:0]      Dalja1,
   output logic [W-1:0]      Dalja2,
   output logic [W-1:0]      Dalja3,
   output logic [NPORT-1:0]  Dalja_Valid,
   input  logic [NPORT-1:0]  Dalja_Ready,
   output logic [15:0]       Numeruesi
);

   state_t        state;
   logic [W-1:0]  buf_data;
   logic [NS-1:0] buf_sel;
   logic          sel_ready;
   logic          accept;
   logic          xfer;

   // Only the ready of the port the buffered word is addressed to matters.
   assign sel_ready = Dalja_Ready[buf_sel];
   assign xfer      = (state == MBUSHUR) && sel_ready;

   // Ready is held low during reset so nothing is accepted in that cycle.
   // When full, a draining output frees the slot in the same cycle.
   assign Hyrje_Ready = Reset_n && ((state == BOSH) || sel_ready);
   assign accept      = Hyrje_Valid && Hyrje_Ready;

   regjistri_buferi #(
      .WIDTH(W + NS)
   ) u_buf (
      .clk     (Clock),
      .clear_n (Reset_n),
      .load    (accept),
      .d       ({Hyrje, S}),
      .q       ({buf_data, buf_sel})
   );

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state     <= BOSH;
         Numeruesi <= '0;
      end else begin
         case (state)
            BOSH: begin
               if (accept) begin
                  state <= MBUSHUR;
               end
            end
            MBUSHUR: begin
               // Simultaneous drain and accept keeps the buffer full: no bubble.
               if (xfer && !accept) begin
                  state <= BOSH;
               end
            end
            default: state <= BOSH;
         endcase
         if (xfer) begin
            Numeruesi <= Numeruesi + 16'd1;
         end
      end
   end

   // One-hot decode of the buffered select; buses of idle ports read zero.
   always_comb begin
      Dalja_Valid = '0;
      if (state == MBUSHUR) begin
         Dalja_Valid[buf_sel] = 1'b1;
      end
      Dalja0 = Dalja_Valid[0] ? buf_data : '0;
      Dalja1 = Dalja_Valid[1] ? buf_data : '0;
      Dalja2 = Dalja_Valid[2] ? buf_data : '0;
      Dalja3 = Dalja_Valid[3] ? buf_data : '0;
   end

endmodule

// File: tb/tb_demux_1n4_reg.sv
// tb/tb_demux_1n4_reg.sv - scoreboard bench for demux_1n4_reg
module tb_demux_1n4_reg;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic [15:0] Hyrje;
   logic [1:0]  S;
   logic        Hyrje_Valid;
   logic        Hyrje_Ready;
   logic [15:0] Dalja0, Dalja1, Dalja2, Dalja3;
   logic [3:0]  Dalja_Valid;
   logic [3:0]  Dalja_Ready;
   logic [15:0] Numeruesi;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [1:0]  port;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];

   logic [15:0] dbus [4];
   assign dbus[0] = Dalja0;
   assign dbus[1] = Dalja1;
   assign dbus[2] = Dalja2;
   assign dbus[3] = Dalja3;

   demux_1n4_reg #(.W(16), .NS(2)) dut (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .Hyrje       (Hyrje),
      .S           (S),
      .Hyrje_Valid (Hyrje_Valid),
      .Hyrje_Ready (Hyrje_Ready),
      .Dalja0      (Dalja0),
      .Dalja1      (Dalja1),
      .Dalja2      (Dalja2),
      .Dalja3      (Dalja3),
      .Dalja_Valid (Dalja_Valid),
      .Dalja_Ready (Dalja_Ready),
      .Numeruesi   (Numeruesi)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc++;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Offer one word; the expected output is queued when the handshake is seen.
   task automatic send(input logic [15:0] d, input logic [1:0] s);
      bit done = 1'b0;
      exp_t e;
      Hyrje       = d;
      S           = s;
      Hyrje_Valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge Clock);
         if (Hyrje_Ready) begin
            e.port = s;
            e.data = d;
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge Clock);
         #1;
      end
      Hyrje_Valid = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Monitor: pops and compares on every output transfer.
   always @(negedge Clock) begin
      exp_t e;
      if (Reset_n === 1'b1) begin
         check("onehot", 32'($countones(Dalja_Valid) <= 1), 32'd1);
         for (int k = 0; k < 4; k++) begin
            if (!Dalja_Valid[k]) check("idle_bus_zero", 32'(dbus[k]), 32'd0);
         end
         for (int k = 0; k < 4; k++) begin
            if (Dalja_Valid[k] && Dalja_Ready[k]) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_unexpected actual=port%0d:%0h required=none", k, dbus[k]);
               end else begin
                  e = sb.pop_front();
                  check("sb_port", 32'(k), 32'(e.port));
                  check("sb_data", 32'(dbus[k]), 32'(e.data));
               end
            end
         end
      end
   end

   initial begin
      int start;
      Reset_n     = 1'b0;
      Hyrje       = '0;
      S           = '0;
      Hyrje_Valid = 1'b0;
      Dalja_Ready = 4'b0000;
      tick();
      tick();
      check("rst_valid", 32'(Dalja_Valid), 32'd0);
      check("rst_count", 32'(Numeruesi), 32'd0);
      check("rst_ready_low", 32'(Hyrje_Ready), 32'd0);
      Reset_n = 1'b1;
      #1;
      check("rel_ready_high", 32'(Hyrje_Ready), 32'd1);

      // Single transfer to port 2
      Dalja_Ready = 4'b1111;
      send(16'h1234, 2'd2);
      check("single_bus2", 32'(Dalja2), 32'h1234);
      check("single_valid", 32'(Dalja_Valid), 32'b0100);
      check("single_bus0", 32'(Dalja0), 32'd0);
      check("single_bus1", 32'(Dalja1), 32'd0);
      check("single_bus3", 32'(Dalja3), 32'd0);
      tick();
      check("single_count", 32'(Numeruesi), 32'd1);
      check("single_empty", 32'(Dalja_Valid), 32'd0);

      // Backpressure on port 1 for five cycles
      Dalja_Ready = 4'b0000;
      send(16'hBEEF, 2'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp_bus1", 32'(Dalja1), 32'hBEEF);
         check("bp_valid", 32'(Dalja_Valid), 32'b0010);
         check("bp_ready_low", 32'(Hyrje_Ready), 32'd0);
         tick();
      end
      Dalja_Ready = 4'b0010;
      tick();
      check("bp_drained", 32'(Dalja_Valid), 32'd0);
      check("bp_ready_back", 32'(Hyrje_Ready), 32'd1);
      check("bp_count", 32'(Numeruesi), 32'd2);

      // Streaming four words, one per cycle
      Dalja_Ready = 4'b1111;
      start = cyc;
      send(16'h0A00, 2'd0);
      send(16'h0B11, 2'd1);
      send(16'h0C22, 2'd2);
      send(16'h0D33, 2'd3);
      check("stream_cycles", 32'(cyc - start), 32'd4);
      tick();
      check("stream_count", 32'(Numeruesi), 32'd6);

      // Foreign readies must not drain port 3
      Dalja_Ready = 4'b0111;
      send(16'hCAFE, 2'd3);
      tick();
      tick();
      tick();
      check("foreign_valid", 32'(Dalja_Valid), 32'b1000);
      check("foreign_bus3", 32'(Dalja3), 32'hCAFE);
      check("foreign_count", 32'(Numeruesi), 32'd6);
      check("foreign_ready_low", 32'(Hyrje_Ready), 32'd0);

      // Reset with the buffer still full discards the word
      check("pre_reset_pending", 32'(sb.size()), 32'd1);
      Reset_n = 1'b0;
      tick();
      check("mid_rst_valid", 32'(Dalja_Valid), 32'd0);
      check("mid_rst_bus3", 32'(Dalja3), 32'd0);
      check("mid_rst_count", 32'(Numeruesi), 32'd0);
      check("mid_rst_ready_low", 32'(Hyrje_Ready), 32'd0);
      sb.delete();
      Reset_n = 1'b1;
      #1;
      check("mid_rst_ready_high", 32'(Hyrje_Ready), 32'd1);

      // Counter wrap: 0xFFFF transfers then one more
      Dalja_Ready = 4'b1111;
      for (int i = 0; i < 65535; i++) begin
         send(i[15:0], i[1:0]);
      end
      tick();
      check("wrap_full", 32'(Numeruesi), 32'hFFFF);
      send(16'h5A5A, 2'd0);
      tick();
      check("wrap_zero", 32'(Numeruesi), 32'd0);

      tick();
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
